uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter for the user project area. Drives the serial line routed to mprj_io[6], which the testbench UART monitor decodes.
- Firmware (or LA/Wishbone glue) pushes bytes through a valid/ready handshake into an internal FIFO.
- The block serialises them as 8N1 frames, with an optional second stop bit, at a baud rate set by a clock divider.

Parameters:
- CLK_DIV, 347, clock cycles per bit (40 MHz / 115200); legal range 2..65535.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.
- STOP_BITS, 1, number of stop bits per frame; 1 or 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetb  input  1  asynchronous active-low reset.
- in_valid  input  1  byte on in_data is offered.
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial output, idle high.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  FIFO_AW+1  number of bytes queued, excluding the byte currently shifting.

Behaviour:
- Reset (resetb low, asynchronous):
  - tx=1, busy=0, fifo_count=0, in_ready=1.
  - State=IDLE; pointers, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high with no glitch-free requirement, and queued bytes are discarded.
- Push:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (fifo_count < 2**FIFO_AW), combinational from registered count only; it must not depend on in_valid.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - in_data must be held stable by the source until accepted.
- Pop:
  - A byte is popped only on frame start.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo depth.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If fifo_count>0, pop into shift register, go to START, and drive tx=0 at this edge (tx is registered).
  - START: tx=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles; bit index 0..7, then STOP.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles. At the end, if fifo_count>0, pop and go directly to START with tx=0 (no idle gap); else go to IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1.
  - Reloads to 0 on every bit boundary and on entering START from IDLE/STOP.
  - The width must hold CLK_DIV-1.
- Timing:
  - With FIFO empty and state IDLE, a byte accepted at edge N produces tx falling at edge N+1.
  - The frame occupies exactly (9+STOP_BITS)*CLK_DIV cycles.
  - Back-to-back frames have period (9+STOP_BITS)*CLK_DIV with no extra cycles.
- busy = (state != IDLE) || (fifo_count != 0). It deasserts on the edge where STOP completes with an empty FIFO.

Test Plan:
- CLK_DIV=4, STOP_BITS=1: push 0xA5 into an idle block.
  - Required: tx falls 1 cycle after acceptance.
  - Required bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles.
  - Required: busy drops after 40 cycles.
- Push 0x55, then 0x0F, back-to-back.
  - Required: the second start bit begins exactly 40 cycles after the first.
  - Required: no idle high cycles between frames.
  - Required: a tbuart-style decoder reads 0x55, 0x0F.
- Hold in_valid with bytes 0x00..0x09 while the first frame is running.
  - Required: 9 accepted (1 shifting + 8 queued).
  - Required: in_ready=0 with fifo_count=8.
  - Required: a push during a full-cycle pop is refused; in_ready returns 1 after the next frame start.
  - Required: all 9 bytes are output in order.
- STOP_BITS=2, CLK_DIV=3: push 0xFF, 0x80.
  - Required: stop period of 6 cycles; frame period 33 cycles.
- Assert resetb low mid-DATA with 3 bytes queued.
  - Required: tx=1, busy=0, fifo_count=0 immediately, with no clock needed.
  - Required: after release, the next push 0x3C transmits cleanly.
- CLK_DIV=347 at 40 MHz: send "AB40".
  - Required: the testbench UART prints the string.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a START/DATA/STOP serialiser.
// The baud rate is CLK_DIV clocks per bit, with one or two stop bits.
module uart_tx_fifo #(
    parameter int CLK_DIV   = 347,
    parameter int FIFO_AW   = 3,
    parameter int STOP_BITS = 1
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int            DEPTH     = 1 << FIFO_AW;
    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        baud, baud_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [1:0]           stop_idx, stop_idx_n;
    logic [7:0]           shreg, shreg_n;
    logic                 tx_n;
    logic                 push, pop, bit_end;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;

    // Full is exactly the MSB of the count, so in_ready never looks at in_valid.
    assign in_ready = ~fifo_count[FIFO_AW];
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign bit_end  = (baud == BAUD_LAST);

    always_comb begin
        state_n    = state;
        baud_n     = bit_end ? '0 : baud + 1'b1;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        tx_n       = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n    = STOP;
                        tx_n       = 1'b1;
                        stop_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx != STOP_LAST) begin
                        stop_idx_n = stop_idx + 1'b1;
                    end else if (fifo_count != '0) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shreg_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            stop_idx   <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations, a serial decoder per instance
// popping a scoreboard queue, plus directed cycle-exact timing checks.
module tb_uart_tx_fifo;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic       rst [3] = '{1'b1, 1'b1, 1'b1};
    logic       vld [3];
    logic [7:0] dat [3];
    logic       tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       txv [3], rdyv [3], bsyv [3];
    logic [3:0] cntv [3];

    assign txv[0] = tx0;   assign txv[1] = tx1;   assign txv[2] = tx2;
    assign rdyv[0] = rdy0; assign rdyv[1] = rdy1; assign rdyv[2] = rdy2;
    assign bsyv[0] = bsy0; assign bsyv[1] = bsy1; assign bsyv[2] = bsy2;
    assign cntv[0] = cnt0; assign cntv[1] = cnt1; assign cntv[2] = cnt2;

    uart_tx_fifo #(.CLK_DIV(4), .FIFO_AW(3), .STOP_BITS(1)) u_a (
        .clock(clock), .resetb(rst[0]), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy0), .tx(tx0), .busy(bsy0), .fifo_count(cnt0));
    uart_tx_fifo #(.CLK_DIV(3), .FIFO_AW(3), .STOP_BITS(2)) u_b (
        .clock(clock), .resetb(rst[1]), .in_valid(vld[1]), .in_data(dat[1]),
        .in_ready(rdy1), .tx(tx1), .busy(bsy1), .fifo_count(cnt1));
    uart_tx_fifo #(.CLK_DIV(347), .FIFO_AW(3), .STOP_BITS(1)) u_c (
        .clock(clock), .resetb(rst[2]), .in_valid(vld[2]), .in_data(dat[2]),
        .in_ready(rdy2), .tx(tx2), .busy(bsy2), .fifo_count(cnt2));

    int         compares = 0;
    int         errs     = 0;
    int         epoch [3];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    string      str_c = "";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        compares++;
        errs++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    task automatic push(input int k, input logic [7:0] d);
        int w = 0;
        vld[k] = 1'b1;
        dat[k] = d;
        while (rdyv[k] !== 1'b1 && w < 2000) begin @(negedge clock); w++; end
        if (w >= 2000) timeout($sformatf("push%0d", k));
        else case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
        @(negedge clock);
        vld[k] = 1'b0;
    endtask

    task automatic wait_tx(input int k, input logic v, output int t);
        int w = 0;
        while (txv[k] !== v && w < 500) begin @(negedge clock); w++; end
        if (w >= 500) timeout($sformatf("wait_tx%0d", k));
        t = cyc;
    endtask

    task automatic wait_idle(input int k, input int bound);
        int w = 0;
        while (bsyv[k] !== 1'b0 && w < bound) begin @(negedge clock); w++; end
        if (w >= bound) timeout($sformatf("wait_idle%0d", k));
        repeat (2) @(negedge clock);
    endtask

    // Mid-bit sampling decoder; frames cut short by a reset are dropped.
    task automatic mon(input int k, input int div);
        logic [7:0] b, e;
        int         ep;
        logic       got;
        forever begin
            @(negedge clock);
            if (txv[k] === 1'b0) begin
                ep = epoch[k];
                b  = '0;
                repeat (div + div / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    b[i] = txv[k];
                    if (i < 7) repeat (div) @(negedge clock);
                end
                repeat (div) @(negedge clock);
                if (ep == epoch[k]) begin
                    chk($sformatf("stop_bit%0d", k), txv[k], 1);
                    got = 1'b0;
                    e   = '0;
                    case (k)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                    endcase
                    if (!got) begin
                        compares++;
                        errs++;
                        $display("FAIL rx%0d: got %02h expected no byte", k, b);
                    end else begin
                        chk($sformatf("rx%0d", k), b, e);
                    end
                    if (k == 2) str_c = $sformatf("%s%c", str_c, b);
                end
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t1, t2, tmp, i, w;
        logic       held;
        logic [9:0] seq;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; dat[k] = '0; epoch[k] = 0;
        end
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_tx%0d", k), txv[k], 1);
            chk($sformatf("rst_busy%0d", k), bsyv[k], 0);
            chk($sformatf("rst_count%0d", k), cntv[k], 0);
            chk($sformatf("rst_ready%0d", k), rdyv[k], 1);
        end
        @(negedge clock); @(negedge clock);
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        fork
            mon(0, 4);
            mon(1, 3);
            mon(2, 347);
        join_none
        @(negedge clock);

        // 0xA5 into an idle block: start, 1,0,1,0,0,1,0,1, stop
        seq = 10'b1101001010;
        push(0, 8'hA5);
        chk("a5_pre_fall", txv[0], 1);
        @(negedge clock);
        for (int n = 0; n < 40; n++) begin
            chk($sformatf("a5_bit%0d", n / 4), txv[0], seq[n / 4]);
            if (n == 39) chk("a5_busy_end", bsyv[0], 1);
            @(negedge clock);
        end
        chk("a5_busy_drop", bsyv[0], 0);
        wait_idle(0, 200);

        // back-to-back frames, second start exactly 40 cycles later
        push(0, 8'h55);
        push(0, 8'h0F);
        wait_tx(0, 1'b0, t1);
        repeat (39) @(negedge clock);
        chk("gap_high", txv[0], 1);
        @(negedge clock);
        chk("second_start", txv[0], 0);
        wait_idle(0, 200);

        // hold in_valid with 0x00..0x09 until the FIFO fills
        vld[0] = 1'b1;
        i = 0;
        while (rdyv[0] === 1'b1 && i < 10) begin
            dat[0] = i[7:0];
            q0.push_back(i[7:0]);
            i++;
            @(negedge clock);
        end
        dat[0] = 8'h09;
        chk("accepted", i, 9);
        chk("full_count", cntv[0], 8);
        chk("full_ready", rdyv[0], 0);
        w = 0;
        held = 1'b1;
        while (rdyv[0] !== 1'b1 && w < 200) begin
            if (cntv[0] !== 4'd8) held = 1'b0;
            @(negedge clock);
            w++;
        end
        chk("full_held", held, 1);
        chk("ready_return", rdyv[0], 1);
        chk("refused_on_pop", cntv[0], 7);
        q0.push_back(8'h09);
        @(negedge clock);
        vld[0] = 1'b0;
        wait_idle(0, 1000);

        // two stop bits, CLK_DIV=3: frame period 33
        push(1, 8'hFF);
        push(1, 8'h80);
        wait_tx(1, 1'b0, t1);
        wait_tx(1, 1'b1, tmp);
        wait_tx(1, 1'b0, t2);
        chk("period_33", t2 - t1, 33);
        repeat (23) @(negedge clock);
        chk("b80_bit6", txv[1], 0);
        repeat (8) @(negedge clock);
        chk("b80_stop2", txv[1], 1);
        @(negedge clock);
        chk("b80_busy_end", bsyv[1], 1);
        @(negedge clock);
        chk("b80_busy_drop", bsyv[1], 0);
        wait_idle(1, 200);

        // asynchronous reset mid-DATA with three bytes queued
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        push(0, 8'h44);
        repeat (10) @(negedge clock);
        chk("queued3", cntv[0], 3);
        #2;
        rst[0] = 1'b0;
        q0.delete();
        epoch[0]++;
        #1;
        chk("arst_tx", txv[0], 1);
        chk("arst_busy", bsyv[0], 0);
        chk("arst_count", cntv[0], 0);
        chk("arst_ready", rdyv[0], 1);
        @(negedge clock);
        rst[0] = 1'b1;
        repeat (40) @(negedge clock);
        push(0, 8'h3C);
        wait_idle(0, 200);
        chk("post_rst_drain", q0.size(), 0);

        // full-rate divider: "AB40"
        push(2, 8'h41);
        push(2, 8'h42);
        push(2, 8'h34);
        push(2, 8'h30);
        wait_idle(2, 20000);
        repeat (5) @(negedge clock);
        compares++;
        if (str_c != "AB40") begin
            errs++;
            $display("FAIL tbuart_string: got \"%s\" expected \"AB40\"", str_c);
        end
        $display("tbuart: %s", str_c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
        $finish;
    end

endmodule
